// File: rtl/ahb_slave_mc.sv
// AHB-Lite slave with per-channel down/up stream FIFOs, a STATUS word and a byte-addressable CSR file.
// Blocked FIFO accesses insert wait states and, if STALL_MAX is non-zero, time out with a two-cycle ERROR.
module ahb_slave_mc #(
    parameter int ADDRESSWIDTH    = 32,
    parameter int DATAWIDTH       = 32,
    parameter int NUM_CH          = 2,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int NUMREGS         = 32,
    parameter int STALL_MAX       = 256
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        HSEL,
    input  logic                        HWRITE,
    input  logic                        HREADY,
    input  logic [ADDRESSWIDTH-1:0]     HADDR,
    input  logic [2:0]                  HSIZE,
    input  logic [2:0]                  HBURST,
    input  logic [3:0]                  HPROT,
    input  logic [1:0]                  HTRANS,
    input  logic [DATAWIDTH-1:0]        HWDATA,
    output logic                        HREADYOUT,
    output logic                        HRESP,
    output logic [DATAWIDTH-1:0]        HRDATA,
    input  logic [NUM_CH-1:0]           down_rd_en,
    output logic [NUM_CH*DATAWIDTH-1:0] down_rd_data,
    output logic [NUM_CH-1:0]           down_empty,
    input  logic [NUM_CH-1:0]           up_wr_en,
    input  logic [NUM_CH*DATAWIDTH-1:0] up_wr_data,
    output logic [NUM_CH-1:0]           up_full,
    input  logic [ADDRESSWIDTH-1:0]     u_addr,
    input  logic                        u_write,
    input  logic [DATAWIDTH-1:0]        u_write_data,
    output logic [DATAWIDTH-1:0]        u_read_data
);

    localparam int BYTES = DATAWIDTH / 8;
    localparam int BLOG  = $clog2(BYTES);
    localparam int WW    = $clog2(NUMREGS);
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int SCW   = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;

    localparam logic [ADDRESSWIDTH-1:0] A_NCH     = ADDRESSWIDTH'(NUM_CH);
    localparam logic [ADDRESSWIDTH-1:0] A_NREG    = ADDRESSWIDTH'(NUMREGS);
    localparam logic [2:0]              FULL_SIZE = 3'(BLOG);
    localparam logic [CW-1:0]           C_FULL    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_STALL, S_ERR1, S_ERR2} state_t;

    state_t              state_q;
    logic                wr_q;
    logic [WW-1:0]       idx_q;
    logic [BLOG-1:0]     off_q;
    logic [2:0]          size_q;
    logic [SCW-1:0]      stall_cnt_q;

    logic [DATAWIDTH-1:0] csr_q  [NUMREGS];
    logic [DATAWIDTH-1:0] dmem_q [NUM_CH][FIFO_DEPTH];
    logic [DATAWIDTH-1:0] umem_q [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]        dwp_q [NUM_CH];
    logic [PW-1:0]        drp_q [NUM_CH];
    logic [CW-1:0]        dcnt_q[NUM_CH];
    logic [PW-1:0]        uwp_q [NUM_CH];
    logic [PW-1:0]        urp_q [NUM_CH];
    logic [CW-1:0]        ucnt_q[NUM_CH];

    logic [ADDRESSWIDTH-1:0] addr_word;
    logic [BLOG-1:0]         a_mask;
    logic                    a_err, a_valid, accept;
    state_t                  next_phase;
    logic [CHW-1:0]          cur_ch;
    logic                    is_dp_q, is_status_q, blocked, in_data, done;
    logic                    ahb_push, ahb_pop, csr_wr, u_hit;
    logic [NUM_CH-1:0]       dn_push, dn_pop, up_push, up_pop, dn_full_v, up_empty_v;
    logic [BYTES-1:0]        lane_sel;
    logic [DATAWIDTH-1:0]    bmask, status_w, rd_word;
    logic                    unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    always_comb begin
        addr_word = HADDR >> BLOG;
        a_mask = '0;
        for (int unsigned i = 0; i < BLOG; i++) a_mask[i] = (i < 32'(HSIZE));
        a_err = (addr_word >= A_NREG) || (HSIZE > FULL_SIZE)
             || ((HADDR[BLOG-1:0] & a_mask) != '0)
             || ((addr_word < A_NCH) && (HSIZE != FULL_SIZE))
             || (HWRITE && (addr_word == A_NCH));
    end

    assign a_valid    = HSEL && HREADY && HTRANS[1];
    assign next_phase = a_err ? S_ERR1 : S_DATA;

    assign cur_ch      = idx_q[CHW-1:0];
    assign is_dp_q     = idx_q < WW'(NUM_CH);
    assign is_status_q = idx_q == WW'(NUM_CH);

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dn_full_v[c]  = dcnt_q[c] == C_FULL;
            up_empty_v[c] = ucnt_q[c] == '0;
        end
    end

    // Stall decisions use only registered FIFO occupancy, so a same-cycle user pop/push unblocks one cycle later.
    assign blocked  = is_dp_q && (wr_q ? dn_full_v[cur_ch] : up_empty_v[cur_ch]);
    assign in_data  = (state_q == S_DATA) || (state_q == S_STALL);
    assign done     = in_data && !blocked;
    assign accept   = a_valid && ((state_q == S_IDLE) || (state_q == S_ERR2) || done);
    assign ahb_push = done && wr_q && is_dp_q;
    assign ahb_pop  = done && !wr_q && is_dp_q;
    assign csr_wr   = done && wr_q && !is_dp_q && !is_status_q;
    assign u_hit    = (u_addr > A_NCH) && (u_addr < A_NREG);

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dn_push[c] = ahb_push && (cur_ch == CHW'(c));
            dn_pop[c]  = down_rd_en[c] && (dcnt_q[c] != '0);
            up_push[c] = up_wr_en[c] && (ucnt_q[c] != C_FULL);
            up_pop[c]  = ahb_pop && (cur_ch == CHW'(c));
        end
    end

    always_comb begin
        bmask = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            lane_sel[b] = (b >= 32'(off_q)) && (b < 32'(off_q) + (32'd1 << size_q));
            bmask[b*8 +: 8] = {8{lane_sel[b]}};
        end
        status_w = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            status_w[c]               = !up_empty_v[c];
            status_w[DATAWIDTH/2 + c] = dn_full_v[c];
        end
        if (is_dp_q)          rd_word = umem_q[cur_ch][urp_q[cur_ch]];
        else if (is_status_q) rd_word = status_w;
        else                  rd_word = csr_q[idx_q];
    end

    always_comb begin
        HREADYOUT = 1'b1;
        case (state_q)
            S_DATA, S_STALL: HREADYOUT = !blocked;
            S_ERR1:          HREADYOUT = 1'b0;
            default:         HREADYOUT = 1'b1;
        endcase
        HRESP  = (state_q == S_ERR1) || (state_q == S_ERR2);
        HRDATA = (done && !wr_q) ? (rd_word & bmask) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                wr_q   <= HWRITE;
                idx_q  <= addr_word[WW-1:0];
                off_q  <= HADDR[BLOG-1:0];
                size_q <= HSIZE;
            end
            case (state_q)
                S_IDLE, S_ERR2: state_q <= accept ? next_phase : S_IDLE;
                S_DATA: begin
                    if (done) begin
                        state_q <= accept ? next_phase : S_IDLE;
                    end else if (STALL_MAX == 1) begin
                        state_q <= S_ERR1;
                    end else begin
                        state_q     <= S_STALL;
                        stall_cnt_q <= SCW'(1);
                    end
                end
                S_STALL: begin
                    // The DATA cycle already counted as the first wait state.
                    if (done) begin
                        state_q     <= accept ? next_phase : S_IDLE;
                        stall_cnt_q <= '0;
                    end else if (STALL_MAX != 0 && stall_cnt_q == SCW'(STALL_MAX - 1)) begin
                        state_q     <= S_ERR1;
                        stall_cnt_q <= '0;
                    end else if (STALL_MAX != 0) begin
                        stall_cnt_q <= stall_cnt_q + SCW'(1);
                    end
                end
                S_ERR1:  state_q <= S_ERR2;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                dwp_q[c]  <= '0;
                drp_q[c]  <= '0;
                dcnt_q[c] <= '0;
                uwp_q[c]  <= '0;
                urp_q[c]  <= '0;
                ucnt_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (dn_push[c]) dwp_q[c] <= dwp_q[c] + PW'(1);
                if (dn_pop[c])  drp_q[c] <= drp_q[c] + PW'(1);
                if (dn_push[c] && !dn_pop[c])      dcnt_q[c] <= dcnt_q[c] + CW'(1);
                else if (!dn_push[c] && dn_pop[c]) dcnt_q[c] <= dcnt_q[c] - CW'(1);
                if (up_push[c]) uwp_q[c] <= uwp_q[c] + PW'(1);
                if (up_pop[c])  urp_q[c] <= urp_q[c] + PW'(1);
                if (up_push[c] && !up_pop[c])      ucnt_q[c] <= ucnt_q[c] + CW'(1);
                else if (!up_push[c] && up_pop[c]) ucnt_q[c] <= ucnt_q[c] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (dn_push[c]) dmem_q[c][dwp_q[c]] <= HWDATA;
            if (up_push[c]) umem_q[c][uwp_q[c]] <= up_wr_data[c*DATAWIDTH +: DATAWIDTH];
        end
    end

    // A user write to the same CSR is applied last so it overrides the whole AHB write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NUMREGS; r++) csr_q[r] <= '0;
        end else begin
            if (csr_wr) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (lane_sel[b]) csr_q[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
            if (u_write && u_hit) csr_q[u_addr[WW-1:0]] <= u_write_data;
        end
    end

    always_comb begin
        down_rd_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            down_rd_data[c*DATAWIDTH +: DATAWIDTH] = dmem_q[c][drp_q[c]];
            down_empty[c] = dcnt_q[c] == '0;
            up_full[c]    = ucnt_q[c] == C_FULL;
        end
    end

    assign u_read_data = u_hit ? csr_q[u_addr[WW-1:0]] : '0;

endmodule

// File: doc/ahb_slave_mc.md
Name: ahb_slave_mc

Overview:
- AHB-Lite slave with NUM_CH independent stream channels and a byte-addressable CSR file with a user-side port.
- Each channel has a down FIFO (AHB write to user) and an up FIFO (user to AHB read).
- Wait states are inserted on full/empty FIFOs. An optional stall timeout ends a blocked access with a proper two-cycle ERROR response.
- Sits between the system AHB fabric and custom user logic.

Parameters:
- ADDRESSWIDTH, 32, AHB address width.
- DATAWIDTH, 32, bus/register/FIFO word width; multiple of 16, at least 32.
- NUM_CH, 2, number of channels; 1 to DATAWIDTH/2.
- FIFO_DEPTH, 16, entries per FIFO; power of two.
- FIFO_DEPTH_LOG2, 4, log2(FIFO_DEPTH).
- NUMREGS, 32, total word slots in the map; must exceed NUM_CH+1.
- STALL_MAX, 256, wait-state limit before ERROR; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- HSEL, HWRITE, HREADY  in  1 each  AHB-Lite controls.
- HADDR  in  ADDRESSWIDTH  AHB address.
- HSIZE, HBURST  in  3 each  AHB size and burst (HBURST ignored).
- HPROT  in  4  ignored.
- HTRANS  in  2  AHB transfer type.
- HWDATA  in  DATAWIDTH  AHB write data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATAWIDTH  AHB read data.
- down_rd_en  in  NUM_CH  user pops down FIFO c.
- down_rd_data  out  NUM_CH*DATAWIDTH  show-ahead head of down FIFO c, slice c.
- down_empty  out  NUM_CH  down FIFO c empty.
- up_wr_en  in  NUM_CH  user pushes up FIFO c.
- up_wr_data  in  NUM_CH*DATAWIDTH  push data, slice c.
- up_full  out  NUM_CH  up FIFO c full.
- u_addr  in  ADDRESSWIDTH  user CSR word index.
- u_write  in  1  user CSR word write.
- u_write_data  in  DATAWIDTH  user CSR write data.
- u_read_data  out  DATAWIDTH  combinational CSR[u_addr]; 0 if u_addr is out of range.

Behaviour:

Address map (word index w = HADDR>>log2(DATAWIDTH/8)):
- w < NUM_CH: data port of channel w. Write pushes down FIFO w; read pops up FIFO w. Full-word access only.
- w = NUM_CH: STATUS, read-only. Bit c = up FIFO c non-empty; bit DATAWIDTH/2+c = down FIFO c full.
- NUM_CH < w < NUMREGS: CSR[w], read/write, byte/halfword/word access.

Address phase:
- Sampled when HSEL & HREADY & HTRANS in {NONSEQ, SEQ}.
- IDLE and BUSY transfers get a zero-wait OKAY with no side effects.

Errors:
- Conditions: w ≥ NUMREGS; HSIZE > log2(DATAWIDTH/8); misalignment; sub-word access to a data port; write to STATUS.
- Response: cycle 1 HREADYOUT=0 HRESP=1; cycle 2 HREADYOUT=1 HRESP=1.
- No side effects: no push, no pop, no CSR change.

FSM states: IDLE, DATA, STALL, ERR1, ERR2.
- IDLE → DATA on a valid address phase; → ERR1 on an error.
- DATA completes immediately (HREADYOUT=1) unless a data-port write hits a full down FIFO or a data-port read hits an empty up FIFO; then → STALL.
- STALL holds HREADYOUT=0 and counts wait cycles. It completes the cycle the FIFO condition clears, based on registered flags.
- STALL → ERR1 when the count reaches STALL_MAX (if STALL_MAX ≠ 0). The timed-out access has no side effect.
- ERR1 → ERR2 → IDLE, or directly to the next pipelined address phase sampled in ERR2.
- Back-to-back transfers: the next address phase is accepted in the completing cycle.

Write data path:
- Push/CSR write uses HWDATA in the completing data-phase cycle.
- Sub-word CSR writes update only the lanes selected by HADDR low bits and HSIZE.
- u_write to the same CSR in the same cycle wins over the AHB write for the whole word.

Read data path:
- HRDATA is valid only in the completing cycle; otherwise 0.
- Data-port reads pop in that cycle. Sub-word CSR reads return the addressed lanes; other lanes read 0.

FIFOs:
- Simultaneous push and pop on one FIFO are both performed; count is unchanged.
- User pop while empty and user push while full are ignored.
- A user pop in the same cycle as a stalled AHB push unblocks the push on the next cycle.

Reset (async, any state, including mid-stall or mid-error):
- FSM to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
- All FIFOs empty: down_empty all 1, up_full all 0.
- CSRs 0; stall counter 0.

Test Plan:
1. Word write 0xA5A5_0001 to channel 1 data port (NUM_CH=2) → down_empty[1]=0 next cycle, down_rd_data slice 1 = 0xA5A5_0001, zero wait states.
2. Fill down FIFO 0 with 16 writes, then write a 17th → HREADYOUT=0. Pulse down_rd_en[0] once → write completes the next cycle and the FIFO is full again.
3. Read channel 0 up FIFO while empty, STALL_MAX=8 → 8 wait cycles, then HREADYOUT=0/HRESP=1 followed by 1/1. FIFO and CSRs unchanged.
4. Byte write 0x7E to CSR[5] at byte 2, then word read → HRDATA = 0x007E_0000. A halfword write at an odd address → ERROR, CSR unchanged.
5. Push 3 entries on up FIFO 1 from the user side, read STATUS → bit 1 = 1. Do three reads → data returned in order, then STATUS bit 1 = 0.
6. Assert reset_n low during a STALL → HREADYOUT=1 immediately, all FIFOs empty, CSR[5]=0.
